fetch_unit: RTL and testbench

Instruction fetch stage for the 8051 core, sitting directly downstream of the program ROM and upstream of the decoder. Drives the ROM address/enable one byte per cycle, buffers bytes in a small prefetch queue, and presents complete 1–3 byte instructions to the decoder with a valid/ready handshake. A redirect input (jumps, calls, interrupt vectors, RETI) flushes the queue and restarts fetch at a new address.

---
 rtl/fetch_pkg.sv | 88 ++++++++
 rtl/fetch_byte_queue.sv | 74 +++++++
 rtl/fetch_unit.sv | 118 +++++++++++
 tb/tb_fetch_unit.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types, defaults and the 8051 opcode length table used
//               by the instruction fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

    // Default program address width
    localparam int c_ADDR_W = 16;

    // Fetch stage control states
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

    // Standard 8051 instruction length (1..3 bytes) derived from the opcode
    function automatic logic [1:0] instr_length(input logic [7:0] opcode);
        logic [3:0] hi;
        logic [3:0] lo;
        logic [1:0] len;
        hi  = opcode[7:4];
        lo  = opcode[3:0];
        len = 2'd1;
        if (lo >= 4'h8) begin
            // Register (Rn) forms
            case (hi)
                4'h7, 4'h8, 4'hA, 4'hD: len = 2'd2;
                4'hB:                   len = 2'd3;
                default:                len = 2'd1;
            endcase
        end else begin
            case (lo)
                4'h0: begin
                    case (hi)
                        4'h0, 4'hE, 4'hF:       len = 2'd1;
                        4'h1, 4'h2, 4'h3, 4'h9: len = 2'd3;
                        default:                len = 2'd2;
                    endcase
                end
                // AJMP / ACALL page forms
                4'h1: len = 2'd2;
                4'h2: begin
                    case (hi)
                        4'h0, 4'h1:             len = 2'd3;
                        4'h2, 4'h3, 4'hE, 4'hF: len = 2'd1;
                        default:                len = 2'd2;
                    endcase
                end
                4'h3: begin
                    case (hi)
                        4'h4, 4'h5, 4'h6: len = 2'd3;
                        default:          len = 2'd1;
                    endcase
                end
                4'h4: begin
                    case (hi)
                        4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h9: len = 2'd2;
                        4'hB:                                     len = 2'd3;
                        default:                                  len = 2'd1;
                    endcase
                end
                4'h5: begin
                    case (hi)
                        4'h7, 4'h8, 4'hB, 4'hD: len = 2'd3;
                        4'hA:                   len = 2'd1;
                        default:                len = 2'd2;
                    endcase
                end
                // Indirect (@Ri) forms, low nibble 6 and 7
                default: begin
                    case (hi)
                        4'h7, 4'h8, 4'hA: len = 2'd2;
                        4'hB:             len = 2'd3;
                        default:          len = 2'd1;
                    endcase
                end
            endcase
        end
        return len;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_byte_queue.sv
// ============================================================================
// Module      : fetch_byte_queue
// Description : Shift-style byte queue; entry 0 is always the head. Supports
//               one push, a 0..3 byte pop and a flush per cycle, and exposes
//               the occupancy and the three head bytes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_byte_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [7:0]       i_push_data,
    input  logic             i_pop,
    input  logic [1:0]       i_pop_len,
    output logic [CNT_W-1:0] o_count,
    output logic [7:0]       o_head0,
    output logic [7:0]       o_head1,
    output logic [7:0]       o_head2
);

    logic [7:0]       r_mem      [DEPTH];
    logic [7:0]       w_next_mem [DEPTH];
    logic [7:0]       w_ext      [DEPTH+3];
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_pop_n;
    logic [CNT_W-1:0] w_remain;

    // Shift surviving bytes toward the head and drop the pushed byte at the new tail
    always_comb begin
        w_pop_n  = i_pop ? CNT_W'(i_pop_len) : '0;
        w_remain = r_count - w_pop_n;
        for (int k = 0; k < DEPTH; k++) begin
            w_ext[k] = r_mem[k];
        end
        for (int k = DEPTH; k < DEPTH + 3; k++) begin
            w_ext[k] = 8'h00;
        end
        for (int i = 0; i < DEPTH; i++) begin
            w_next_mem[i] = r_mem[i];
            for (int j = 0; j < 4; j++) begin
                if (w_pop_n == CNT_W'(j)) begin
                    w_next_mem[i] = w_ext[i + j];
                end
            end
            if (i_push && (w_remain == CNT_W'(i))) begin
                w_next_mem[i] = i_push_data;
            end
        end
    end

    // Occupancy and storage update; reset and flush both empty the queue
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_flush) begin
            r_count <= '0;
        end else begin
            r_count <= w_remain + CNT_W'(i_push);
        end
        r_mem <= w_next_mem;
    end

    assign o_count = r_count;
    assign o_head0 = r_mem[0];
    assign o_head1 = r_mem[1];
    assign o_head2 = r_mem[2];

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module      : fetch_unit
// Description : 8051 instruction fetch stage. Reads the program ROM one byte
//               per cycle into a prefetch queue and hands complete 1-3 byte
//               instructions to the decoder over a valid/ready handshake.
//               A redirect flushes the queue and restarts fetch.
//               Build option FETCH_PREFETCH_EN: when defined the queue fills to
//               QDEPTH bytes; otherwise fetch stops once the head instruction
//               is complete. QDEPTH must be at least 3.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W,
    parameter int QDEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_byte,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [7:0]        instr_opcode,
    output logic [7:0]        instr_op1,
    output logic [7:0]        instr_op2,
    output logic [1:0]        instr_len,
    output logic [ADDR_W-1:0] instr_pc
);

    localparam int c_CNT_W = $clog2(QDEPTH + 1);

    fetch_state_t       r_state;
    logic [ADDR_W-1:0]  r_fetch_pc;
    logic [ADDR_W-1:0]  r_head_pc;
    logic [c_CNT_W-1:0] w_count;
    logic [7:0]         w_head0;
    logic [7:0]         w_head1;
    logic [7:0]         w_head2;
    logic [1:0]         w_len;
    logic               w_run;
    logic               w_valid;
    logic               w_rom_en;
    logic               w_xfer;

    assign w_run   = (r_state == RUN);
    assign w_len   = instr_length(w_head0);
    // Length is never zero, so an empty queue is never valid
    assign w_valid = w_run && (int'(w_count) >= int'(w_len));
    assign w_xfer  = w_valid && instr_ready;

`ifdef FETCH_PREFETCH_EN
    assign w_rom_en = w_run && (int'(w_count) < QDEPTH);
`else
    // Head byte is stale when empty, hence the explicit empty term
    assign w_rom_en = w_run && ((w_count == '0) || (int'(w_count) < int'(w_len)));
`endif

    fetch_byte_queue #(
        .DEPTH (QDEPTH),
        .CNT_W (c_CNT_W)
    ) u_queue (
        .i_clk       (clock),
        .i_rst_n     (reset),
        .i_flush     (redirect_valid),
        .i_push      (w_rom_en),
        .i_push_data (rom_byte),
        .i_pop       (w_xfer),
        .i_pop_len   (w_len),
        .o_count     (w_count),
        .o_head0     (w_head0),
        .o_head1     (w_head1),
        .o_head2     (w_head2)
    );

    // Control FSM plus fetch/head address tracking; redirect overrides both
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_fetch_pc <= '0;
            r_head_pc  <= '0;
        end else begin
            case (r_state)
                IDLE:    r_state <= RUN;
                RUN:     r_state <= RUN;
                default: r_state <= IDLE;
            endcase
            if (redirect_valid) begin
                r_fetch_pc <= redirect_addr;
                r_head_pc  <= redirect_addr;
            end else begin
                if (w_rom_en) begin
                    r_fetch_pc <= r_fetch_pc + 1'b1;
                end
                if (w_xfer) begin
                    r_head_pc <= r_head_pc + ADDR_W'(w_len);
                end
            end
        end
    end

    assign rom_en       = w_rom_en;
    assign rom_addr     = r_fetch_pc;
    assign instr_valid  = w_valid;
    assign instr_opcode = w_valid ? w_head0 : 8'h00;
    assign instr_op1    = (w_valid && (w_len >= 2'd2)) ? w_head1 : 8'h00;
    assign instr_op2    = (w_valid && (w_len == 2'd3)) ? w_head2 : 8'h00;
    assign instr_len    = w_valid ? w_len : 2'd0;
    assign instr_pc     = w_valid ? r_head_pc : '0;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit: directed start-up, stall,
//               redirect, wrap and reset scenarios, then randomized traffic
//               compared every cycle against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

    localparam int ADDR_W = 16;
    localparam int QDEPTH = 4;
`ifdef FETCH_PREFETCH_EN
    localparam int c_STALL_FETCHES = 4;
`else
    localparam int c_STALL_FETCHES = 3;
`endif

    logic              clock;
    logic              reset;
    logic              rom_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_byte;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_addr;
    logic              instr_valid;
    logic              instr_ready;
    logic [7:0]        instr_opcode;
    logic [7:0]        instr_op1;
    logic [7:0]        instr_op2;
    logic [1:0]        instr_len;
    logic [ADDR_W-1:0] instr_pc;

    logic [7:0]  rom [65536];
    logic [42:0] dut_vec;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit          m_known = 0;
    bit          m_run   = 0;
    logic [15:0] m_fetch = '0;
    logic [15:0] m_head  = '0;
    logic [7:0]  m_q[$];

    fetch_unit #(.ADDR_W(ADDR_W), .QDEPTH(QDEPTH)) dut (
        .clock          (clock),
        .reset          (reset),
        .rom_en         (rom_en),
        .rom_addr       (rom_addr),
        .rom_byte       (rom_byte),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_opcode   (instr_opcode),
        .instr_op1      (instr_op1),
        .instr_op2      (instr_op2),
        .instr_len      (instr_len),
        .instr_pc       (instr_pc)
    );

    assign rom_byte = rom[rom_addr];
    assign dut_vec  = {instr_valid, instr_opcode, instr_op1, instr_op2, instr_len, instr_pc};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // 8051 opcode lengths, listed by instruction group
    function automatic int ref_len(input logic [7:0] op);
        if (op inside {8'h02, 8'h12, 8'h10, 8'h20, 8'h30, 8'h43, 8'h53, 8'h63,
                       8'h75, 8'h85, 8'h90, 8'hB4, 8'hB5, 8'hB6, 8'hB7,
                       [8'hB8:8'hBF], 8'hD5})
            return 3;
        if (op[3:0] == 4'h1)
            return 2;
        if (op inside {8'h05, 8'h15, 8'h25, 8'h35, 8'h45, 8'h55, 8'h65, 8'h95,
                       8'hC5, 8'hE5, 8'hF5,
                       8'h24, 8'h34, 8'h44, 8'h54, 8'h64, 8'h74, 8'h94,
                       8'h40, 8'h50, 8'h60, 8'h70, 8'h80, 8'hA0, 8'hB0, 8'hC0, 8'hD0,
                       8'h42, 8'h52, 8'h62, 8'h72, 8'h82, 8'h92, 8'hA2, 8'hB2, 8'hC2, 8'hD2,
                       8'h76, 8'h77, 8'h86, 8'h87, 8'hA6, 8'hA7,
                       [8'h78:8'h7F], [8'h88:8'h8F], [8'hA8:8'hAF], [8'hD8:8'hDF]})
            return 2;
        return 1;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Compare DUT against the model for this cycle, advance the model, then the clock
    task automatic step();
        int          len;
        bit          e_valid;
        bit          e_en;
        logic [42:0] e_vec;
        len     = (m_q.size() > 0) ? ref_len(m_q[0]) : 1;
        e_valid = m_run && (m_q.size() > 0) && (m_q.size() >= len);
`ifdef FETCH_PREFETCH_EN
        e_en    = m_run && (m_q.size() < QDEPTH);
`else
        e_en    = m_run && ((m_q.size() == 0) || (m_q.size() < len));
`endif
        e_vec   = '0;
        if (e_valid)
            e_vec = {1'b1, m_q[0], (len >= 2) ? m_q[1] : 8'h00,
                     (len == 3) ? m_q[2] : 8'h00, 2'(len), m_head};
        if (m_known) begin
            check("model_rom_en", 64'(rom_en), 64'(e_en));
            check("model_rom_addr", 64'(rom_addr), 64'(m_fetch));
            check("model_instr", 64'(dut_vec), 64'(e_vec));
        end
        if (!reset) begin
            m_known = 1;
            m_run   = 0;
            m_q.delete();
            m_fetch = '0;
            m_head  = '0;
        end else if (m_known) begin
            if (e_valid && instr_ready) begin
                repeat (len) void'(m_q.pop_front());
                m_head = m_head + 16'(len);
            end
            if (redirect_valid) begin
                m_q.delete();
                m_fetch = redirect_addr;
                m_head  = redirect_addr;
            end else if (e_en) begin
                m_q.push_back(rom[m_fetch]);
                m_fetch = m_fetch + 16'd1;
            end
            m_run = 1;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic wait_valid(input string name, input int max_cycles);
        int n = 0;
        while (!instr_valid && n < max_cycles) begin
            step();
            n++;
        end
        check(name, 64'(instr_valid), 64'd1);
    endtask

    initial begin : main
        int          nf;
        int          nfa;
        int          npc;
        logic [15:0] fa  [3];
        logic [15:0] pcs [2];

        for (int a = 0; a < 65536; a++) rom[a] = 8'($urandom);
        reset          = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr  = '0;
        #1;

        // Start-up
        rom[0] = 8'h74;
        rom[1] = 8'h02;
        step();
        step();
        check("reset_rom_en", 64'(rom_en), 64'd0);
        check("reset_rom_addr", 64'(rom_addr), 64'd0);
        check("reset_instr", 64'(dut_vec), 64'd0);
        reset       = 1'b1;
        instr_ready = 1'b1;
        check("c1_rom_en", 64'(rom_en), 64'd0);
        step();
        check("c2_rom_addr", 64'(rom_addr), 64'h0000);
        check("c2_rom_en", 64'(rom_en), 64'd1);
        step();
        check("c3_rom_addr", 64'(rom_addr), 64'h0001);
        step();
        check("c4_instr", 64'(dut_vec), 64'({1'b1, 8'h74, 8'h02, 8'h00, 2'd2, 16'h0000}));

        // Decoder stall from start-up
        reset       = 1'b0;
        instr_ready = 1'b0;
        rom[0] = 8'h02;
        rom[1] = 8'h00;
        rom[2] = 8'h0B;
        rom[3] = 8'h55;
        step();
        reset = 1'b1;
        nf = 0;
        repeat (12) begin
            if (rom_en) nf++;
            step();
        end
        check("stall_fetches", 64'(nf), 64'(c_STALL_FETCHES));
        check("stall_rom_en", 64'(rom_en), 64'd0);
        check("stall_instr", 64'(dut_vec), 64'({1'b1, 8'h02, 8'h00, 8'h0B, 2'd3, 16'h0000}));

        // Redirect during a stall
        rom[16'h000B] = 8'h24;
        rom[16'h000C] = 8'h01;
        rom[16'h000D] = 8'h32;
        redirect_valid = 1'b1;
        redirect_addr  = 16'h000B;
        step();
        redirect_valid = 1'b0;
        check("redir_rom_addr", 64'(rom_addr), 64'h000B);
        check("redir_valid", 64'(instr_valid), 64'd0);
        wait_valid("redir_wait1", 10);
        check("redir_i1", 64'(dut_vec), 64'({1'b1, 8'h24, 8'h01, 8'h00, 2'd2, 16'h000B}));
        instr_ready = 1'b1;
        step();
        wait_valid("redir_wait2", 10);
        check("redir_i2", 64'(dut_vec), 64'({1'b1, 8'h32, 8'h00, 8'h00, 2'd1, 16'h000D}));

        // Address wrap-around
        rom[16'hFFFE] = 8'h00;
        rom[16'hFFFF] = 8'h00;
        redirect_valid = 1'b1;
        redirect_addr  = 16'hFFFE;
        step();
        redirect_valid = 1'b0;
        nfa = 0;
        npc = 0;
        foreach (fa[k]) fa[k] = 16'h1234;
        foreach (pcs[k]) pcs[k] = 16'h1234;
        repeat (12) begin
            if (rom_en && nfa < 3) begin
                fa[nfa] = rom_addr;
                nfa++;
            end
            if (instr_valid && instr_ready && npc < 2) begin
                pcs[npc] = instr_pc;
                npc++;
            end
            step();
        end
        check("wrap_fetch0", 64'(fa[0]), 64'hFFFE);
        check("wrap_fetch1", 64'(fa[1]), 64'hFFFF);
        check("wrap_fetch2", 64'(fa[2]), 64'h0000);
        check("wrap_pc0", 64'(pcs[0]), 64'hFFFE);
        check("wrap_pc1", 64'(pcs[1]), 64'hFFFF);

        // Reset with three bytes queued
        instr_ready    = 1'b0;
        redirect_valid = 1'b1;
        redirect_addr  = 16'h0000;
        step();
        redirect_valid = 1'b0;
        repeat (3) step();
        check("mid_valid_before", 64'(instr_valid), 64'd1);
        reset = 1'b0;
        step();
        check("mid_valid", 64'(instr_valid), 64'd0);
        check("mid_rom_en", 64'(rom_en), 64'd0);
        check("mid_rom_addr", 64'(rom_addr), 64'h0000);
        reset = 1'b1;
        step();
        check("restart_rom_addr", 64'(rom_addr), 64'h0000);
        check("restart_rom_en", 64'(rom_en), 64'd1);

        // Randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            instr_ready    = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 23) == 0);
            if ($urandom_range(0, 2) == 0)
                redirect_addr = 16'hFFF0 + 16'($urandom_range(0, 15));
            else
                redirect_addr = 16'($urandom);
            reset = ($urandom_range(0, 199) != 0);
            step();
        end
        reset          = 1'b1;
        redirect_valid = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
